// File: rtl/event_encoder.sv
// event_encoder: serialises a one-cycle event pulse vector into an AXI4-Stream of event codes.
// Define EVENT_ENCODER_TIMESTAMP_EN to put a 25-bit write-time cycle counter in tdata[31:7].
module event_encoder #(
    parameter int DATA_WIDTH      = 66,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       m_axis_tready,
    output logic [31:0]                m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       overflow,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_count
);
    localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
    logic [DATA_WIDTH-1:0]      pending, served;
    logic [6:0]                 sel;
    logic [31:0]                word;
    logic [31:0]                mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]   count;
    logic                       full, rd, wr;
    assign m_axis_tvalid = count != '0;
    assign full          = count == (FIFO_ADDR_WIDTH+1)'(DEPTH);
    assign rd            = m_axis_tvalid & m_axis_tready;
    assign wr            = |pending && (!full || rd);
    assign served        = wr ? DATA_WIDTH'(1) << sel : '0;
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;
    assign fifo_count    = count;
    // scanning downwards leaves the lowest set index in sel
    always_comb begin
        sel = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--)
            if (pending[i]) sel = 7'(i);
    end
`ifdef EVENT_ENCODER_TIMESTAMP_EN
    logic [24:0] ts;
    always_ff @(posedge aclk)
        ts <= areset ? '0 : ts + 25'd1;
    assign word = {ts, sel};
`else
    assign word = {25'd0, sel};
`endif
    always_ff @(posedge aclk) begin
        if (areset) begin
            pending  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= (pending & ~served) | din;
            if (|(din & pending & ~served)) overflow <= 1'b1;
            if (wr) wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
            if (rd) rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
            count <= count + (FIFO_ADDR_WIDTH+1)'(wr) - (FIFO_ADDR_WIDTH+1)'(rd);
        end
    end
    always_ff @(posedge aclk)
        if (wr) mem[wr_ptr] <= word;
endmodule

// File: tb/tb_event_encoder.sv
// tb_event_encoder: directed vectors against hand-computed event words for event_encoder.
module tb_event_encoder;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [65:0] din = '0;
    logic        m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        overflow;
    logic [4:0]  fifo_count;
    int          checks = 0;
    int          errors = 0;
    int          rx[$];
    int          valid_cycles;

    event_encoder dut (
        .aclk(aclk), .areset(areset), .din(din), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic pulse(input int idx);
        din = '0;
        din[idx] = 1'b1;
        step();
        din = '0;
    endtask

    // records every transfer over a bounded window with tready held high
    task automatic drain(input int cycles);
        rx.delete();
        m_axis_tready = 1'b1;
        repeat (cycles) begin
            if (m_axis_tvalid) begin
                rx.push_back(int'(m_axis_tdata[6:0]));
                check("tdata_upper_zero", 64'(m_axis_tdata[31:7]), 64'd0);
            end
            step();
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        step(2);
        areset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);

        m_axis_tready = 1'b1;
        pulse(5);
        check("single_c1_tvalid", 64'(m_axis_tvalid), 64'd0);
        step();
        check("single_c2_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("single_c2_tdata", 64'(m_axis_tdata), 64'd5);
        step();
        check("single_c3_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("single_overflow", 64'(overflow), 64'd0);

        din = '0;
        din[65] = 1'b1;
        din[3] = 1'b1;
        din[0] = 1'b1;
        step();
        din = '0;
        step();
        check("multi_w0", 64'(m_axis_tdata), 64'd0);
        check("multi_w0_valid", 64'(m_axis_tvalid), 64'd1);
        step();
        check("multi_w1", 64'(m_axis_tdata), 64'd3);
        check("multi_w1_valid", 64'(m_axis_tvalid), 64'd1);
        step();
        check("multi_w2", 64'(m_axis_tdata), 64'd65);
        check("multi_w2_valid", 64'(m_axis_tvalid), 64'd1);
        step();
        check("multi_end_valid", 64'(m_axis_tvalid), 64'd0);

        din = '0;
        din[9] = 1'b1;
        step();
        step();
        din = '0;
        drain(10);
        check("reserve_words", 64'(rx.size()), 64'd2);
        if (rx.size() == 2) begin
            check("reserve_w0", 64'(rx[0]), 64'd9);
            check("reserve_w1", 64'(rx[1]), 64'd9);
        end
        check("reserve_no_overflow", 64'(overflow), 64'd0);

        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) pulse(10 + i);
        step(6);
        check("full_count", 64'(fifo_count), 64'd16);
        check("full_tvalid", 64'(m_axis_tvalid), 64'd1);
        drain(40);
        check("full_words", 64'(rx.size()), 64'd20);
        for (int i = 0; i < 20 && i < rx.size(); i++)
            check($sformatf("full_order_%0d", i), 64'(rx[i]), 64'(10 + i));
        check("full_overflow", 64'(overflow), 64'd0);
        check("full_drained", 64'(fifo_count), 64'd0);

        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) pulse(40 + i);
        step(2);
        check("ovf_full", 64'(fifo_count), 64'd16);
        pulse(7);
        step();
        check("ovf_before", 64'(overflow), 64'd0);
        pulse(7);
        step();
        check("ovf_set", 64'(overflow), 64'd1);
        drain(40);
        check("ovf_words", 64'(rx.size()), 64'd17);
        for (int i = 0; i < 16 && i < rx.size(); i++)
            check($sformatf("ovf_order_%0d", i), 64'(rx[i]), 64'(40 + i));
        if (rx.size() == 17) check("ovf_last", 64'(rx[16]), 64'd7);
        check("ovf_sticky", 64'(overflow), 64'd1);
        do_reset();
        check("ovf_cleared", 64'(overflow), 64'd0);

        m_axis_tready = 1'b0;
        din = '0;
        for (int i = 20; i <= 26; i++) din[i] = 1'b1;
        step();
        din = '0;
        step(5);
        check("rst_mid_count", 64'(fifo_count), 64'd5);
        areset = 1'b1;
        step();
        areset = 1'b0;
        check("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_mid_count0", 64'(fifo_count), 64'd0);
        check("rst_mid_overflow", 64'(overflow), 64'd0);
        m_axis_tready = 1'b1;
        valid_cycles = 0;
        repeat (20) begin
            if (m_axis_tvalid) valid_cycles++;
            step();
        end
        check("rst_mid_no_stale", 64'(valid_cycles), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
